multi_pulse: RTL and testbench
==============================

# multi_pulse

Parametrised multi-channel pulse generator, the successor to the single-channel 8-bit millisecond pulse block. Each channel independently produces a pulse of 0..2^LEN_WIDTH-1 ticks on a trigger rising edge, in one-shot, retriggerable or periodic mode, with synchronous abort and an end-of-pulse strobe. It sits between the satellite register file (lengths, modes, triggers) and the output drivers, all in the masterClk domain.

## Interface
- CHANNELS, 4, number of independent channels (1..32)
- LEN_WIDTH, 8, pulse length register width per channel (1..16)
- TICK_CYCLES, 1000, masterClk cycles per length tick (≥2); the top level sets it to the master-clock cycles per ms
- masterClk  in  1  master clock, all logic on posedge
- nReset  in  1  synchronous, active-low reset
- trigger  in  CHANNELS  per-channel trigger level; rising edge starts a pulse
- abort  in  CHANNELS  per-channel synchronous abort, level-sensitive
- pulseLength  in  CHANNELS*LEN_WIDTH  channel i at [i*LEN_WIDTH +: LEN_WIDTH], in ticks
- mode  in  CHANNELS*2  channel i at [2*i +: 2]: 00 one-shot, 01 retriggerable, 10 periodic, 11 treated as 00
- pulse  out  CHANNELS  registered pulse outputs
- pulseInv  out  CHANNELS  registered, always ~pulse
- done  out  CHANNELS  one-cycle strobe when a pulse ends naturally

## Operation
- Per channel: trigger history register prevTrig, prescaler (clog2(TICK_CYCLES) bits, counts 0..TICK_CYCLES-1), tick counter (LEN_WIDTH bits), latched length, latched mode, state.
- Edge: trigger sampled 1 with prevTrig 0. prevTrig updates every cycle regardless of state.
- States: IDLE, HIGH, LOW (LOW used in periodic only).
- IDLE + edge + pulseLength≠0 → HIGH; latch length and mode, prescaler←0, count←length, pulse←1.
- IDLE + edge + pulseLength=0 → stay IDLE, no pulse, no done.
- HIGH: prescaler increments; at TICK_CYCLES-1 it wraps to 0 and count decrements. When count reaches 0: one-shot/retrig → IDLE, pulse←0, done←1; periodic → LOW, count←latched length, pulse←0, no done.
- LOW (periodic): same tick counting; at expiry → HIGH, count←latched length, pulse←1. Runs until abort.
- Edge while HIGH, mode 00/10: ignored. Edge while HIGH, mode 01: count←current pulseLength, prescaler←0, pulse stays 1; if current pulseLength=0, pulse ends next cycle with done.
- Edge while LOW (periodic): ignored.
- Mode and length inputs changing mid-pulse have no effect (latched), except the mode-01 reload above.
- abort=1: state→IDLE, pulse←0 next edge, done not asserted, edges on that cycle are discarded. abort has priority over trigger and expiry.
- Channels are fully independent; no shared prescaler.

## Timing
- Reset (nReset=0 at posedge): pulse=0, pulseInv=all 1, done=0, all states IDLE, prescalers and counters 0, prevTrig←1 (a trigger held high across reset release does not fire).
- Latency: trigger low at posedge k-1, high at posedge k → pulse=1 after posedge k.
- Pulse width: exactly L*TICK_CYCLES cycles high; done is high for the single cycle immediately following the last high cycle (same edge pulse falls).
- Periodic: high L*TICK_CYCLES, low L*TICK_CYCLES, repeat; period 2*L*TICK_CYCLES.
- Minimum re-trigger in one-shot: a new edge is accepted on the cycle pulse first reads 0.
- Length arithmetic unsigned; max length 2^LEN_WIDTH-1 ticks; no wrap of the counter below 0.

## Test plan
- TICK_CYCLES=4, ch0 mode 00, length 3, single trigger edge -> pulse high exactly 12 cycles starting 1 cycle after edge; done 1 cycle at fall; pulseInv complementary throughout.
- Same, second edge at cycle 5 of the pulse -> ignored, width still 12; edge on first low cycle -> new 12-cycle pulse.
- ch1 mode 01, length 3, re-edge at cycle 6 with pulseLength=2 -> pulse continuous, ends 8 cycles after re-edge, one done only.
- ch2 mode 10, length 2 -> 8 high / 8 low repeating for ≥3 periods, no done; abort at cycle 10 -> pulse 0 next cycle, stays IDLE.
- pulseLength=0 edge -> no pulse, no done; trigger high through reset release -> no pulse; abort and edge in same cycle -> no pulse.
- All CHANNELS triggered on different cycles with different lengths -> each width independent and exact; nReset mid-pulse -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/multi_pulse.sv
// multi_pulse: per-channel one-shot, retriggerable or periodic pulse generator with abort and done strobe
module multi_pulse #(
    parameter int CHANNELS    = 4,
    parameter int LEN_WIDTH   = 8,
    parameter int TICK_CYCLES = 1000
) (
    input  logic                          masterClk,
    input  logic                          nReset,
    input  logic [CHANNELS-1:0]           trigger,
    input  logic [CHANNELS-1:0]           abort,
    input  logic [CHANNELS*LEN_WIDTH-1:0] pulseLength,
    input  logic [CHANNELS*2-1:0]         mode,
    output logic [CHANNELS-1:0]           pulse,
    output logic [CHANNELS-1:0]           pulseInv,
    output logic [CHANNELS-1:0]           done
);
    localparam int PW = $clog2(TICK_CYCLES);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t               state, state_n;
        logic                 prev_trig, trig_edge, tick, expire;
        logic [PW-1:0]        presc, presc_n;
        logic [LEN_WIDTH-1:0] cnt, cnt_n, len_q, len_n, len_in;
        logic [1:0]           mode_q, mode_n, mode_in;
        logic                 pulse_q, pulse_n, inv_q, done_q, done_n;
        assign len_in    = pulseLength[i*LEN_WIDTH +: LEN_WIDTH];
        assign mode_in   = mode[2*i +: 2];
        assign trig_edge = trigger[i] & ~prev_trig;
        assign tick      = presc == PW'(TICK_CYCLES - 1);
        // a zero count can only appear after a mode-01 reload with length 0
        assign expire    = cnt == '0 || (tick && cnt == LEN_WIDTH'(1));
        assign pulse[i]    = pulse_q;
        assign pulseInv[i] = inv_q;
        assign done[i]     = done_q;
        always_comb begin
            state_n = state;
            presc_n = tick ? '0 : presc + 1'b1;
            cnt_n   = (tick && cnt != '0) ? cnt - 1'b1 : cnt;
            len_n   = len_q;
            mode_n  = mode_q;
            pulse_n = pulse_q;
            done_n  = 1'b0;
            if (abort[i]) begin
                state_n = IDLE;
                presc_n = '0;
                cnt_n   = '0;
                pulse_n = 1'b0;
            end else if (state == IDLE) begin
                presc_n = presc;
                cnt_n   = cnt;
                if (trig_edge && len_in != '0) begin
                    state_n = HIGH;
                    len_n   = len_in;
                    mode_n  = mode_in;
                    presc_n = '0;
                    cnt_n   = len_in;
                    pulse_n = 1'b1;
                end
            end else if (state == HIGH && trig_edge && mode_q == 2'b01) begin
                presc_n = '0;
                cnt_n   = len_in;
            end else if (expire) begin
                presc_n = '0;
                cnt_n   = mode_q == 2'b10 ? len_q : '0;
                pulse_n = mode_q == 2'b10 && state == LOW;
                state_n = mode_q != 2'b10 ? IDLE : (state == HIGH ? LOW : HIGH);
                done_n  = mode_q != 2'b10;
            end
        end
        always_ff @(posedge masterClk) begin
            if (!nReset) begin
                state     <= IDLE;
                prev_trig <= 1'b1;
                presc     <= '0;
                cnt       <= '0;
                len_q     <= '0;
                mode_q    <= '0;
                pulse_q   <= 1'b0;
                inv_q     <= 1'b1;
                done_q    <= 1'b0;
            end else begin
                state     <= state_n;
                prev_trig <= trigger[i];
                presc     <= presc_n;
                cnt       <= cnt_n;
                len_q     <= len_n;
                mode_q    <= mode_n;
                pulse_q   <= pulse_n;
                inv_q     <= ~pulse_n;
                done_q    <= done_n;
            end
        end
    end
endmodule

// File: tb/tb_multi_pulse.sv
// tb_multi_pulse: directed checks of multi_pulse with TICK_CYCLES=4
module tb_multi_pulse;
    logic        masterClk = 1'b0;
    logic        nReset;
    logic [3:0]  trigger, abort, pulse, pulseInv, done;
    logic [31:0] pulseLength;
    logic [7:0]  mode;
    int errors = 0;
    int checks = 0;

    multi_pulse #(.CHANNELS(4), .LEN_WIDTH(8), .TICK_CYCLES(4)) dut (
        .masterClk(masterClk), .nReset(nReset), .trigger(trigger), .abort(abort),
        .pulseLength(pulseLength), .mode(mode), .pulse(pulse), .pulseInv(pulseInv), .done(done)
    );

    always #5 masterClk = ~masterClk;

    task automatic cyc();
        @(posedge masterClk);
        #1;
    endtask

    // counts high cycles from now until the fall, plus done strobes and inversion errors
    task automatic measure(input int ch, output int w, output int d, output int ib);
        w = 0; d = 0; ib = 0;
        while (pulse[ch] && w < 200) begin
            if (pulseInv[ch] !== ~pulse[ch]) ib++;
            if (done[ch]) d++;
            w++;
            cyc();
        end
        if (pulseInv[ch] !== ~pulse[ch]) ib++;
        if (done[ch]) d++;
        cyc();
        if (done[ch]) d++;
    endtask

    task automatic test_reset();
        nReset = 1'b0; trigger = '0; abort = '0; pulseLength = '0; mode = '0;
        cyc(); cyc();
        checks++; if (pulse !== 4'h0) begin errors++; $display("FAIL reset_pulse got %h want 0", pulse); end
        checks++; if (pulseInv !== 4'hF) begin errors++; $display("FAIL reset_inv got %h want f", pulseInv); end
        checks++; if (done !== 4'h0) begin errors++; $display("FAIL reset_done got %h want 0", done); end
        nReset = 1'b1;
        cyc();
    endtask

    task automatic test_oneshot();
        int w, d, ib;
        pulseLength[7:0] = 8'd3; mode[1:0] = 2'b00;
        trigger[0] = 1'b1;
        cyc();
        checks++; if (pulse[0] !== 1'b1) begin errors++; $display("FAIL oneshot_latency got %b want 1", pulse[0]); end
        measure(0, w, d, ib);
        trigger[0] = 1'b0;
        checks++; if (w != 12) begin errors++; $display("FAIL oneshot_width got %0d want 12", w); end
        checks++; if (d != 1) begin errors++; $display("FAIL oneshot_done got %0d want 1", d); end
        checks++; if (ib != 0) begin errors++; $display("FAIL oneshot_inv got %0d bad cycles want 0", ib); end
    endtask

    task automatic test_ignore_and_retrigger();
        int w, d, ib;
        cyc();
        trigger[0] = 1'b1;
        cyc();
        w = 0;
        while (pulse[0] && w < 200) begin
            w++;
            if (w == 2) trigger[0] = 1'b0;
            if (w == 5) trigger[0] = 1'b1;
            if (w == 6) trigger[0] = 1'b0;
            cyc();
        end
        checks++; if (w != 12) begin errors++; $display("FAIL ignore_width got %0d want 12", w); end
        checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL ignore_done got %b want 1", done[0]); end
        trigger[0] = 1'b1;
        cyc();
        checks++; if (pulse[0] !== 1'b1) begin errors++; $display("FAIL first_low_edge got %b want 1", pulse[0]); end
        measure(0, w, d, ib);
        trigger[0] = 1'b0;
        checks++; if (w != 12) begin errors++; $display("FAIL first_low_width got %0d want 12", w); end
    endtask

    task automatic test_retrig_mode();
        int w, d;
        pulseLength[15:8] = 8'd3; mode[3:2] = 2'b01;
        trigger[1] = 1'b1;
        cyc();
        w = 0; d = 0;
        while (pulse[1] && w < 200) begin
            if (done[1]) d++;
            w++;
            if (w == 3) trigger[1] = 1'b0;
            if (w == 6) begin trigger[1] = 1'b1; pulseLength[15:8] = 8'd2; end
            cyc();
        end
        if (done[1]) d++;
        cyc();
        if (done[1]) d++;
        trigger[1] = 1'b0;
        checks++; if (w != 14) begin errors++; $display("FAIL retrig_width got %0d want 14", w); end
        checks++; if (d != 1) begin errors++; $display("FAIL retrig_done got %0d want 1", d); end
    endtask

    task automatic test_periodic();
        int bad, dn, hi;
        pulseLength[23:16] = 8'd2; mode[5:4] = 2'b10;
        trigger[2] = 1'b1;
        cyc();
        bad = 0; dn = 0;
        for (int c = 0; c < 48; c++) begin
            if (pulse[2] !== 1'((c / 8) % 2 == 0)) bad++;
            if (done[2]) dn++;
            cyc();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL periodic_shape got %0d bad cycles want 0", bad); end
        checks++; if (dn != 0) begin errors++; $display("FAIL periodic_done got %0d want 0", dn); end
        cyc(); cyc();
        abort[2] = 1'b1;
        cyc();
        abort[2] = 1'b0;
        checks++; if (pulse[2] !== 1'b0) begin errors++; $display("FAIL abort_pulse got %b want 0", pulse[2]); end
        checks++; if (done[2] !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done[2]); end
        hi = 0;
        for (int c = 0; c < 20; c++) begin
            if (pulse[2] || done[2]) hi++;
            cyc();
        end
        trigger[2] = 1'b0;
        checks++; if (hi != 0) begin errors++; $display("FAIL abort_idle got %0d active cycles want 0", hi); end
    endtask

    task automatic test_corner_cases();
        int hi;
        pulseLength[31:24] = 8'd0; mode[7:6] = 2'b00;
        trigger[3] = 1'b1;
        hi = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (pulse[3] || done[3]) hi++;
        end
        trigger[3] = 1'b0;
        checks++; if (hi != 0) begin errors++; $display("FAIL zero_length got %0d active cycles want 0", hi); end
        trigger[0] = 1'b1;
        nReset = 1'b0;
        cyc();
        nReset = 1'b1;
        hi = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (pulse[0]) hi++;
        end
        trigger[0] = 1'b0;
        checks++; if (hi != 0) begin errors++; $display("FAIL trig_through_reset got %0d high cycles want 0", hi); end
        cyc();
        trigger[0] = 1'b1; abort[0] = 1'b1;
        cyc();
        abort[0] = 1'b0;
        checks++; if (pulse[0] !== 1'b0) begin errors++; $display("FAIL abort_with_edge got %b want 0", pulse[0]); end
        hi = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (pulse[0]) hi++;
        end
        trigger[0] = 1'b0;
        checks++; if (hi != 0) begin errors++; $display("FAIL abort_edge_late got %0d high cycles want 0", hi); end
    endtask

    task automatic test_all_channels();
        int first[4], wid[4], dn[4];
        pulseLength = {8'd4, 8'd3, 8'd2, 8'd1};
        mode = '0;
        trigger = '0;
        cyc();
        for (int k = 0; k < 4; k++) begin first[k] = -1; wid[k] = 0; dn[k] = 0; end
        for (int c = 0; c < 40; c++) begin
            if (c < 4) trigger[c] = 1'b1;
            cyc();
            for (int k = 0; k < 4; k++) begin
                if (pulse[k]) begin
                    if (first[k] < 0) first[k] = c;
                    wid[k]++;
                end
                if (done[k]) dn[k]++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (first[k] != k) begin errors++; $display("FAIL multi_start ch%0d got %0d want %0d", k, first[k], k); end
            checks++; if (wid[k] != 4 * (k + 1)) begin errors++; $display("FAIL multi_width ch%0d got %0d want %0d", k, wid[k], 4 * (k + 1)); end
            checks++; if (dn[k] != 1) begin errors++; $display("FAIL multi_done ch%0d got %0d want 1", k, dn[k]); end
        end
        trigger = '0;
        cyc();
        trigger = 4'hF;
        cyc(); cyc(); cyc();
        checks++; if (pulse !== 4'hF) begin errors++; $display("FAIL mid_reset_pre got %h want f", pulse); end
        nReset = 1'b0;
        cyc();
        checks++; if (pulse !== 4'h0) begin errors++; $display("FAIL mid_reset_pulse got %h want 0", pulse); end
        checks++; if (pulseInv !== 4'hF) begin errors++; $display("FAIL mid_reset_inv got %h want f", pulseInv); end
        checks++; if (done !== 4'h0) begin errors++; $display("FAIL mid_reset_done got %h want 0", done); end
        nReset = 1'b1;
        trigger = '0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_ignore_and_retrigger();
        test_retrig_mode();
        test_periodic();
        test_corner_cases();
        test_all_channels();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
